// File: rtl/synth_scheduler_if.sv
// Handshake bundle between the granule scheduler, the granule buffers and the synthesis datapath.
// The master modport is the scheduler's view; slave is the buffer/synthesis side.
interface synth_scheduler_if;
    logic [1:0]  gr_ready;
    logic        buf_rd_ch;
    logic [9:0]  buf_rd_addr;
    logic [31:0] buf_rd_data;
    logic        synth_frame_start;
    logic [31:0] synth_x;
    logic        synth_x_valid;
    logic        synth_done;
    logic [1:0]  gr_consumed;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  gr_ready, buf_rd_data, synth_done,
        output buf_rd_ch, buf_rd_addr, synth_frame_start, synth_x, synth_x_valid,
               gr_consumed, busy, timeout_err
    );

    modport slave (
        output gr_ready, buf_rd_data, synth_done,
        input  buf_rd_ch, buf_rd_addr, synth_frame_start, synth_x, synth_x_valid,
               gr_consumed, busy, timeout_err
    );
endinterface

// File: rtl/synth_scheduler.sv
// Round-robin granule scheduler: picks a ready channel, streams its granule to the
// synthesis datapath, waits for synth_done (with timeout) and releases the buffer.
//
//   state   | meaning
//   IDLE    | arbitrate between ready channels
//   START   | frame-start pulse, read address 0 issued
//   STREAM  | one sample per cycle to synthesis, next address issued
//   WAIT    | waiting for synth_done or timeout
//   RELEASE | gr_consumed pulse for the granted channel
module synth_scheduler #(
    parameter int SAMPLES = 576,
    parameter int TIMEOUT = 65535
) (
    input logic            clk,
    input logic            rst,
    synth_scheduler_if.master sif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] STREAM  = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic [9:0]  LAST_SAMPLE = 10'(SAMPLES - 1);
    localparam logic [16:0] TMO         = 17'(TIMEOUT);

    logic [2:0]  state;
    logic        cur_ch;
    logic        last_ch;
    logic [9:0]  sample_cnt;
    logic [15:0] wait_cnt;
    logic        timeout_err_q;
    logic        sel_ch;

    // A tie goes to the channel that was not served last.
    always_comb begin
        sel_ch = sif.gr_ready[1];
        if (sif.gr_ready == 2'b11) begin
            sel_ch = ~last_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_ch        <= 1'b0;
            last_ch       <= 1'b1;
            sample_cnt    <= '0;
            wait_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sif.gr_ready != 2'b00) begin
                        cur_ch  <= sel_ch;
                        last_ch <= sel_ch;
                        state   <= START;
                    end
                end
                START: begin
                    sample_cnt <= '0;
                    state      <= STREAM;
                end
                STREAM: begin
                    if (sample_cnt == LAST_SAMPLE) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        sample_cnt <= sample_cnt + 10'd1;
                    end
                end
                WAIT: begin
                    if (sif.synth_done) begin
                        state <= RELEASE;
                    end else if (({1'b0, wait_cnt} + 17'd1) >= TMO) begin
                        wait_cnt      <= TMO[15:0];
                        timeout_err_q <= 1'b1;
                        state         <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the address, so STREAM issues address n+1
    // while presenting sample n straight from the buffer.
    always_comb begin
        sif.buf_rd_addr       = '0;
        sif.synth_frame_start = 1'b0;
        sif.synth_x_valid     = 1'b0;
        sif.gr_consumed       = 2'b00;
        case (state)
            START: begin
                sif.synth_frame_start = 1'b1;
            end
            STREAM: begin
                sif.synth_x_valid = 1'b1;
                sif.buf_rd_addr   = (sample_cnt == LAST_SAMPLE) ? LAST_SAMPLE
                                                                : sample_cnt + 10'd1;
            end
            RELEASE: begin
                sif.gr_consumed = cur_ch ? 2'b10 : 2'b01;
            end
            default: begin
            end
        endcase
    end

    assign sif.synth_x     = sif.synth_x_valid ? sif.buf_rd_data : 32'd0;
    assign sif.buf_rd_ch   = cur_ch;
    assign sif.busy        = (state != IDLE);
    assign sif.timeout_err = timeout_err_q;
endmodule
